dmem_arbiter: RTL
=================

# dmem_arbiter

Sequencing and arbitration controller in front of the word-wide data memory. Shares the single memory port between the core load/store path and a loader/debug port using round-robin arbitration. Generates byte-lane write enables for SB/SH/SW and lane-aligns and extends LB/LH/LW/LBU/LHU read data. Detects misaligned or illegal accesses before they reach memory.

## Interface
Parameters:
- DM_ADDRESS, 9, byte-address width seen by both requesters
- DATA_W, 32, data width (fixed at 32; other values unsupported)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- c_req  in  1  core request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  DM_ADDRESS  core byte address
- c_wdata  in  32  core store data (low bits used for SB/SH)
- c_funct3  in  3  RV32I load/store funct3
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core load data valid (1-cycle pulse)
- c_rdata  out  32  core load data, extended
- c_err  out  1  misaligned/illegal core access (1-cycle pulse)
- l_req, l_we  in  1  loader request / write
- l_addr  in  DM_ADDRESS  loader byte address (low 2 bits ignored, word-only)
- l_wdata  in  32  loader store data
- l_gnt, l_rvalid  out  1  loader accept / read-data-valid pulse
- l_rdata  out  32  loader load data
- m_raddr, m_waddr  out  32  memory read/write word address
- m_wdata  out  32  memory write data
- m_wr  out  4  memory byte write enables
- m_rdata  in  32  memory read data, valid the cycle after m_raddr is presented
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, WR, RD, RESP, ERR.
- IDLE: if any req, pick a port; gnt of that port high combinationally this cycle; latch we/addr/wdata/funct3/port-id at edge. Tie: grant the port not granted last; last-grant resets to loader (core wins first tie).
- Accepted write -> WR; read -> RD; core access with error -> ERR.
- WR: m_waddr = {0, addr[DM_ADDRESS-1:2], 2'b00}; m_wr/m_wdata per funct3; -> IDLE.
  - SB: m_wr = 4'b0001 << addr[1:0], m_wdata = {4{wdata[7:0]}}.
  - SH: m_wr = addr[1] ? 4'b1100 : 4'b0011, m_wdata = {2{wdata[15:0]}}.
  - SW and all loader writes: m_wr = 4'b1111, m_wdata = wdata.
- RD: m_raddr = word address; -> RESP.
- RESP: m_raddr held; m_rdata captured, lane-extracted, extended into the granted port's rdata register; rvalid set for the next cycle; -> IDLE.
  - LB/LBU: byte addr[1:0], sign/zero extend. LH/LHU: half addr[1], sign/zero extend. LW and loader: full word.
- Error (core only): LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; funct3 011, 110, 111; also load funct3 011/110/111 and store funct3 other than 000/001/010. ERR: no memory access, c_err set for next cycle, -> IDLE.
- m_wr = 0 in every state except WR. m_raddr/m_waddr/m_wdata hold last driven values outside their states.
- rdata registers hold until the next load completion for that port.

## Timing
- Reset values: all gnt, rvalid, c_err, busy, m_wr = 0; c_rdata, l_rdata, m_raddr, m_waddr, m_wdata = 0; state IDLE.
- gnt only in IDLE and never during reset; at most one gnt per cycle.
- Grant at cycle T: write m_wr high in T+1; load rvalid high in T+3; error c_err high in T+2.
- rvalid/c_err pulses coincide with IDLE, so a new grant can occur in the same cycle. Throughput: 1 write / 2 cycles, 1 read / 3 cycles.
- Requester holds req and its fields until gnt; fields are don't-care after gnt.
- Reset mid-operation: state -> IDLE at the edge. An in-flight read produces no rvalid. An in-flight write's m_wr is 0 from the reset cycle on. Last-grant returns to loader.
- A port that drops req before gnt loses nothing; no request is queued.

## Test plan
- Reset, then core SW addr 0x010 data 0xDEADBEEF -> c_gnt T, m_wr=1111 and m_waddr=0x010 at T+1; LW 0x010 -> c_rvalid at T+3, c_rdata=0xDEADBEEF.
- SB 0x013 data 0x000000AA -> m_wr=1000, m_wdata=0xAAAAAAAA. Word then 0xAA112233: LB 0x013 -> 0xFFFFFFAA, LBU -> 0x000000AA, LH 0x012 -> 0xFFFFAA11, LHU -> 0x0000AA11.
- Core and loader request every cycle -> grants alternate core, loader, core…; no cycle has both gnt, and m_wr is never asserted outside WR.
- LW 0x012, SH 0x011, funct3 011 -> gnt, no m_wr, c_err pulse at T+2, no c_rvalid; next request is granted normally.
- Loader write l_addr 0x007 data 0x12345678 -> m_waddr=0x004, m_wr=1111; loader read l_addr 0x006 -> l_rvalid with 0x12345678.
- Reset asserted in RD state -> no c_rvalid, busy=0, next cycle after reset release accepts a new request, core wins tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin sharing of the data-memory port between the core
//             load/store path and the loader port, with byte-lane handling
//             and misaligned/illegal access detection.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // core port
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [2:0]            c_funct3,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_err,
    // loader port
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [DM_ADDRESS-1:0] l_addr,
    input  logic [DATA_W-1:0]     l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [DATA_W-1:0]     l_rdata,
    // memory port
    output logic [31:0]           m_raddr,
    output logic [31:0]           m_waddr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [3:0]            m_wr,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  w_any_req;
    logic                  w_pick_l;
    logic                  w_c_gnt;
    logic                  w_l_gnt;
    logic                  w_grant;
    logic                  w_c_illegal;
    logic                  w_sel_we;
    logic [DM_ADDRESS-1:0] w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [2:0]            w_sel_f3;
    logic [31:0]           w_word_addr;
    logic [3:0]            w_lanes;
    logic [DATA_W-1:0]     w_lane_data;
    logic [7:0]            w_rbyte;
    logic [15:0]           w_rhalf;
    logic [DATA_W-1:0]     w_load_data;

    logic                  r_last_core;
    logic                  r_port_l;
    logic [1:0]            r_lane;
    logic [2:0]            r_f3;
    logic [3:0]            r_wmask;
    logic [31:0]           r_m_raddr;
    logic [31:0]           r_m_waddr;
    logic [DATA_W-1:0]     r_m_wdata;
    logic                  r_c_rvalid;
    logic                  r_l_rvalid;
    logic                  r_c_err;
    logic [DATA_W-1:0]     r_c_rdata;
    logic [DATA_W-1:0]     r_l_rdata;

    // Arbitration: on a tie the port that did not win last time is served.
    assign w_any_req = (c_req | l_req) & ~reset;
    assign w_pick_l  = l_req & (~c_req | r_last_core);
    assign w_grant   = w_c_gnt | w_l_gnt;

    always_comb begin
        w_c_illegal = 1'b0;
        if (c_we) begin
            case (c_funct3)
                3'b000:  w_c_illegal = 1'b0;
                3'b001:  w_c_illegal = c_addr[0];
                3'b010:  w_c_illegal = |c_addr[1:0];
                default: w_c_illegal = 1'b1;
            endcase
        end else begin
            case (c_funct3)
                3'b000, 3'b100: w_c_illegal = 1'b0;
                3'b001, 3'b101: w_c_illegal = c_addr[0];
                3'b010:         w_c_illegal = |c_addr[1:0];
                default:        w_c_illegal = 1'b1;
            endcase
        end
    end

    // Loader traffic is always a full word, so it is folded onto the LW/SW encoding.
    assign w_sel_we    = w_pick_l ? l_we    : c_we;
    assign w_sel_addr  = w_pick_l ? l_addr  : c_addr;
    assign w_sel_wdata = w_pick_l ? l_wdata : c_wdata;
    assign w_sel_f3    = w_pick_l ? 3'b010  : c_funct3;
    assign w_word_addr = {{(32-DM_ADDRESS){1'b0}}, w_sel_addr[DM_ADDRESS-1:2], 2'b00};

    always_comb begin
        w_lanes     = 4'b1111;
        w_lane_data = w_sel_wdata;
        case (w_sel_f3)
            3'b000: begin
                w_lanes     = 4'b0001 << w_sel_addr[1:0];
                w_lane_data = {4{w_sel_wdata[7:0]}};
            end
            3'b001: begin
                w_lanes     = w_sel_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{w_sel_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c_gnt     = 1'b0;
        w_l_gnt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_l_gnt = w_pick_l;
                    w_c_gnt = ~w_pick_l;
                    if (~w_pick_l & w_c_illegal) begin
                        w_state_nxt = ST_ERR;
                    end else if (w_sel_we) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_RD:                    w_state_nxt = ST_RESP;
            ST_WR, ST_RESP, ST_ERR:   w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        case (r_lane)
            2'd0:    w_rbyte = m_rdata[7:0];
            2'd1:    w_rbyte = m_rdata[15:8];
            2'd2:    w_rbyte = m_rdata[23:16];
            default: w_rbyte = m_rdata[31:24];
        endcase
        w_rhalf = r_lane[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (r_f3)
            3'b000:  w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
            3'b100:  w_load_data = {24'd0, w_rbyte};
            3'b001:  w_load_data = {{16{w_rhalf[15]}}, w_rhalf};
            3'b101:  w_load_data = {16'd0, w_rhalf};
            default: w_load_data = m_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_core <= 1'b0;
            r_port_l    <= 1'b0;
            r_lane      <= 2'd0;
            r_f3        <= 3'd0;
            r_wmask     <= 4'd0;
            r_m_raddr   <= 32'd0;
            r_m_waddr   <= 32'd0;
            r_m_wdata   <= '0;
            r_c_rvalid  <= 1'b0;
            r_l_rvalid  <= 1'b0;
            r_c_err     <= 1'b0;
            r_c_rdata   <= '0;
            r_l_rdata   <= '0;
        end else begin
            r_c_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
            r_c_err    <= 1'b0;
            if (w_grant) begin
                r_last_core <= w_c_gnt;
                r_port_l    <= w_l_gnt;
                r_lane      <= w_sel_addr[1:0];
                r_f3        <= w_sel_f3;
                if (w_state_nxt == ST_WR) begin
                    r_m_waddr <= w_word_addr;
                    r_m_wdata <= w_lane_data;
                    r_wmask   <= w_lanes;
                end
                if (w_state_nxt == ST_RD) begin
                    r_m_raddr <= w_word_addr;
                end
            end
            if (r_state == ST_RESP) begin
                if (r_port_l) begin
                    r_l_rdata  <= w_load_data;
                    r_l_rvalid <= 1'b1;
                end else begin
                    r_c_rdata  <= w_load_data;
                    r_c_rvalid <= 1'b1;
                end
            end
            if (r_state == ST_ERR) begin
                r_c_err <= 1'b1;
            end
        end
    end

    // Write strobes are masked by reset so an interrupted store never lands.
    assign m_wr     = ((r_state == ST_WR) && !reset) ? r_wmask : 4'b0000;
    assign m_raddr  = r_m_raddr;
    assign m_waddr  = r_m_waddr;
    assign m_wdata  = r_m_wdata;
    assign c_gnt    = w_c_gnt;
    assign l_gnt    = w_l_gnt;
    assign c_rvalid = r_c_rvalid;
    assign l_rvalid = r_l_rvalid;
    assign c_err    = r_c_err;
    assign c_rdata  = r_c_rdata;
    assign l_rdata  = r_l_rdata;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire
